coherent_mem_ctrl: RTL and testbench

COHERENT_MEM_CTRL -- requirements
Module: coherent_mem_ctrl

---
 rtl/coherent_mem_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_coherent_mem_ctrl.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/coherent_mem_ctrl.sv
// Single-port coherent memory controller: round-robin arbitration across
// N requesters, fixed-latency access, and a per-block MSI-style directory
// (I/M/S plus sharer vector) that drives invalidates to prior sharers on writes.
//
// Handshake: a request is accepted in the cycle where req_valid[i] and
// req_ready[i] are both high; req_ready is only ever raised for one requester,
// only in IDLE, and the requester must hold valid and payload until then.
// resp_valid is a one-cycle pulse with no backpressure.
module coherent_mem_ctrl #(
   parameter int MEM_SIZE       = 16384,
   parameter int DATA_SIZE      = 2,
   parameter int BLOCK_SIZE     = 2,
   parameter int LATENCY        = 10,
   parameter int NUM_PROCESSORS = 4,
   parameter int AW             = $clog2(MEM_SIZE / BLOCK_SIZE)
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic [NUM_PROCESSORS-1:0]          req_valid,
   input  logic [NUM_PROCESSORS-1:0]          req_we,
   input  logic [NUM_PROCESSORS*AW-1:0]       req_addr,
   input  logic [NUM_PROCESSORS*DATA_SIZE*8-1:0] req_wdata,
   output logic [NUM_PROCESSORS-1:0]          req_ready,
   output logic [NUM_PROCESSORS-1:0]          resp_valid,
   output logic [DATA_SIZE*8-1:0]             resp_rdata,
   output logic [NUM_PROCESSORS-1:0]          inval_mask,
   output logic                               busy
);

   localparam int N     = NUM_PROCESSORS;
   localparam int DW    = DATA_SIZE * 8;
   localparam int WORDS = MEM_SIZE / BLOCK_SIZE;
   localparam int PW    = (N > 1) ? $clog2(N) : 1;
   localparam int CW    = (LATENCY > 2) ? $clog2(LATENCY) : 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   localparam logic [1:0] DIR_I = 2'b00;
   localparam logic [1:0] DIR_M = 2'b01;
   localparam logic [1:0] DIR_S = 2'b10;

   // Wraps a requester index back into 0..N-1.
   function automatic logic [PW-1:0] wrap_idx(input int a);
      int r;
      r = a;
      if (r >= N) r = r - N;
      return PW'(r);
   endfunction

   state_t            state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [PW-1:0]     rr_ptr_q, rr_ptr_d;
   logic [PW-1:0]     id_q, id_d;
   logic              we_q, we_d;
   logic [AW-1:0]     addr_q, addr_d;
   logic [DW-1:0]     wdata_q, wdata_d;

   logic [DW-1:0]     mem_q       [WORDS];
   logic [1:0]        dir_state_q [WORDS];
   logic [N-1:0]      dir_sh_q    [WORDS];

   logic              gnt_found;
   logic [PW-1:0]     gnt_idx;
   logic [N-1:0]      ready_raw;
   logic              resp_fire;
   logic [N-1:0]      id_oh;
   logic [1:0]        cur_state;
   logic [N-1:0]      cur_sh;
   logic [1:0]        dir_state_d;
   logic [N-1:0]      dir_sh_d;
   logic [N-1:0]      inval_d;

   // Round-robin search: first valid requester at or after rr_ptr.
   always_comb begin
      gnt_found = 1'b0;
      gnt_idx   = '0;
      for (int i = 0; i < N; i++) begin
         if (!gnt_found && req_valid[wrap_idx(int'(rr_ptr_q) + i)]) begin
            gnt_found = 1'b1;
            gnt_idx   = wrap_idx(int'(rr_ptr_q) + i);
         end
      end
   end

   // FSM next state, accept strobe and request latching.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      rr_ptr_d  = rr_ptr_q;
      id_d      = id_q;
      we_d      = we_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      ready_raw = '0;
      case (state_q)
         ST_IDLE: begin
            if (gnt_found) begin
               ready_raw          = '0;
               ready_raw[gnt_idx] = 1'b1;
               id_d               = gnt_idx;
               we_d               = req_we[gnt_idx];
               addr_d             = req_addr[int'(gnt_idx)*AW +: AW];
               wdata_d            = req_wdata[int'(gnt_idx)*DW +: DW];
               cnt_d              = CW'(LATENCY - 2);
               state_d            = ST_BUSY;
            end
         end
         ST_BUSY: begin
            if (cnt_q == '0) state_d = ST_RESP;
            else             cnt_d   = cnt_q - 1'b1;
         end
         ST_RESP: begin
            state_d  = ST_IDLE;
            rr_ptr_d = wrap_idx(int'(id_q) + 1);
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Control and request registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         rr_ptr_q <= '0;
         id_q     <= '0;
         we_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         rr_ptr_q <= rr_ptr_d;
         id_q     <= id_d;
         we_q     <= we_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
      end
   end

   // Directory transition for the addressed block; encoding 11 behaves as I.
   always_comb begin
      resp_fire   = (state_q == ST_RESP);
      id_oh       = '0;
      id_oh[id_q] = 1'b1;
      cur_state   = dir_state_q[addr_q];
      cur_sh      = dir_sh_q[addr_q];
      if (cur_state == 2'b11) cur_state = DIR_I;
      dir_state_d = cur_state;
      dir_sh_d    = cur_sh;
      inval_d     = '0;
      if (we_q) begin
         dir_state_d = DIR_M;
         dir_sh_d    = id_oh;
         if (cur_state != DIR_I) inval_d = cur_sh & ~id_oh;
      end else begin
         case (cur_state)
            DIR_S: dir_sh_d = cur_sh | id_oh;
            DIR_M: begin
               if ((cur_sh & id_oh) == '0) begin
                  dir_state_d = DIR_S;
                  dir_sh_d    = cur_sh | id_oh;
               end
            end
            default: begin
               dir_state_d = DIR_S;
               dir_sh_d    = id_oh;
            end
         endcase
      end
   end

   // Memory and directory storage; both commit only in the response cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < WORDS; i++) begin
            mem_q[i]       <= '0;
            dir_state_q[i] <= DIR_I;
            dir_sh_q[i]    <= '0;
         end
      end else if (resp_fire) begin
         if (we_q) mem_q[addr_q] <= wdata_q;
         dir_state_q[addr_q] <= dir_state_d;
         dir_sh_q[addr_q]    <= dir_sh_d;
      end
   end

   // Outputs decoded from the current state; accept is masked while in reset.
   always_comb begin
      req_ready  = reset ? '0 : ready_raw;
      resp_valid = resp_fire ? id_oh : '0;
      resp_rdata = (resp_fire && !we_q) ? mem_q[addr_q] : '0;
      inval_mask = resp_fire ? inval_d : '0;
      busy       = (state_q != ST_IDLE);
   end

endmodule

// File: tb/tb_coherent_mem_ctrl.sv
// Directed bench for coherent_mem_ctrl with N=4, LATENCY=10.
module tb_coherent_mem_ctrl;

  localparam int N   = 4;
  localparam int LAT = 10;
  localparam int AW  = 13;
  localparam int DW  = 16;

  logic              clk;
  logic              reset;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_we;
  logic [N*AW-1:0]   req_addr;
  logic [N*DW-1:0]   req_wdata;
  logic [N-1:0]      req_ready;
  logic [N-1:0]      resp_valid;
  logic [DW-1:0]     resp_rdata;
  logic [N-1:0]      inval_mask;
  logic              busy;

  int cmp_n = 0;
  int err_n = 0;

  coherent_mem_ctrl #(
    .MEM_SIZE(16384), .DATA_SIZE(2), .BLOCK_SIZE(2),
    .LATENCY(LAT), .NUM_PROCESSORS(N)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .inval_mask(inval_mask), .busy(busy)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp_n++;
    assert (obs === exp) else begin
      err_n++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full transaction from requester p; checks accept, latency and idle return.
  task automatic do_txn(input int p, input logic we, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wd, input string tag,
                        output logic [DW-1:0] rd, output logic [N-1:0] inv);
    int lat;
    logic [N-1:0] exp_oh;
    exp_oh = '0;
    exp_oh[p] = 1'b1;
    @(negedge clk);
    req_valid[p] = 1'b1;
    req_we[p]    = we;
    req_addr[p*AW +: AW] = addr;
    req_wdata[p*DW +: DW] = wd;
    #1;
    check({tag, "_ready"}, 32'(req_ready), 32'(exp_oh));
    @(posedge clk);
    #1;
    req_valid[p] = 1'b0;
    lat = 0;
    rd  = '0;
    inv = '0;
    while (lat < 2*LAT) begin
      @(negedge clk);
      lat++;
      if (resp_valid != '0) break;
    end
    check({tag, "_latency"}, 32'(lat), 32'(LAT));
    check({tag, "_resp_valid"}, 32'(resp_valid), 32'(exp_oh));
    rd  = resp_rdata;
    inv = inval_mask;
    @(negedge clk);
    check({tag, "_after"}, {busy, resp_valid, inval_mask}, 32'h0);
  endtask

  logic [DW-1:0] rd;
  logic [N-1:0]  inv;
  int            g_cyc [$];
  int            g_id  [$];
  int            exp_cyc [5];
  int            exp_id  [5];
  logic          seen_resp;

  initial begin
    reset     = 1'b1;
    req_valid = '0;
    req_we    = '0;
    req_addr  = '0;
    req_wdata = '0;

    // reset state, with a request pending that must not be accepted
    @(negedge clk);
    req_valid = 4'b0010;
    #1;
    check("rst_outputs", {req_ready, resp_valid, inval_mask, resp_rdata, 3'b0, busy}, 32'h0);
    req_valid = '0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("idle_no_req", {req_ready, 3'b0, busy}, 32'h0);

    // P1 writes BEEF to 5
    do_txn(1, 1'b1, 13'd5, 16'hBEEF, "p1_wr", rd, inv);
    check("p1_wr_inval", 32'(inv), 32'h0);
    check("p1_wr_dir", {dut.dir_state_q[5], dut.dir_sh_q[5]}, {2'b01, 4'b0010});

    // P2 reads 5
    do_txn(2, 1'b0, 13'd5, 16'h0, "p2_rd", rd, inv);
    check("p2_rd_data", 32'(rd), 32'hBEEF);
    check("p2_rd_inval", 32'(inv), 32'h0);
    check("p2_rd_dir", {dut.dir_state_q[5], dut.dir_sh_q[5]}, {2'b10, 4'b0110});

    // P3 writes 1234 to 5, invalidating P1 and P2
    do_txn(3, 1'b1, 13'd5, 16'h1234, "p3_wr", rd, inv);
    check("p3_wr_inval", 32'(inv), 32'h6);
    check("p3_wr_dir", {dut.dir_state_q[5], dut.dir_sh_q[5]}, {2'b01, 4'b1000});
    check("p3_wr_mem", 32'(dut.mem_q[5]), 32'h1234);

    // owner reads its own M block: no change
    do_txn(3, 1'b0, 13'd5, 16'h0, "p3_rd", rd, inv);
    check("p3_rd_data", 32'(rd), 32'h1234);
    check("p3_rd_dir", {dut.dir_state_q[5], dut.dir_sh_q[5]}, {2'b01, 4'b1000});

    // another processor reads M block: downgrade to S with owner kept
    do_txn(0, 1'b0, 13'd5, 16'h0, "p0_rd", rd, inv);
    check("p0_rd_data", 32'(rd), 32'h1234);
    check("p0_rd_dir", {dut.dir_state_q[5], dut.dir_sh_q[5]}, {2'b10, 4'b1001});

    // never-written address
    do_txn(2, 1'b0, 13'd100, 16'h0, "p2_rd100", rd, inv);
    check("rd100_data", 32'(rd), 32'h0);
    check("rd100_dir", {dut.dir_state_q[100], dut.dir_sh_q[100]}, {2'b10, 4'b0100});

    // reset pulsed in cycle 5 of a write to 7
    @(negedge clk);
    req_valid[0] = 1'b1;
    req_we[0]    = 1'b1;
    req_addr[0 +: AW]  = 13'd7;
    req_wdata[0 +: DW] = 16'hAAAA;
    #1;
    check("abort_ready", 32'(req_ready), 32'h1);
    @(posedge clk);
    #1;
    req_valid[0] = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    #1;
    check("abort_in_reset", {req_ready, resp_valid, inval_mask, 3'b0, busy}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    seen_resp = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (resp_valid != '0) seen_resp = 1'b1;
    end
    check("abort_no_resp", 32'(seen_resp), 32'h0);
    check("abort_mem7", 32'(dut.mem_q[7]), 32'h0);
    check("abort_dir7", {dut.dir_state_q[7], dut.dir_sh_q[7]}, 32'h0);

    // all four held from reset: round-robin order and spacing
    reset = 1'b1;
    req_we    = '0;
    req_valid = 4'b1111;
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 50; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      if (req_ready != '0) begin
        g_cyc.push_back(c);
        g_id.push_back((req_ready == 4'b0001) ? 0 : (req_ready == 4'b0010) ? 1 :
                       (req_ready == 4'b0100) ? 2 : (req_ready == 4'b1000) ? 3 : 99);
      end
    end
    req_valid = '0;
    exp_cyc = '{0, 11, 22, 33, 44};
    exp_id  = '{0, 1, 2, 3, 0};
    check("rr_count", 32'(g_cyc.size()), 32'd5);
    for (int k = 0; k < 5; k++) begin
      if (k < g_cyc.size()) begin
        check($sformatf("rr_cycle%0d", k), 32'(g_cyc[k]), 32'(exp_cyc[k]));
        check($sformatf("rr_id%0d", k), 32'(g_id[k]), 32'(exp_id[k]));
      end
    end

    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
    $finish;
  end

endmodule
